parking_gate_ctrl: RTL and testbench

- Sequences the entry and exit gates of the 4-spot parking lot.
- Owns the spot-occupancy register and assigns each arriving car the lowest-indexed free spot.
- Arbitrates when entry and exit requests arrive together.
- Computes the free-spot count (number of zero bits in the occupancy register) that feeds the lot display.

---
 rtl/parking_gate_ctrl_if.sv | 32 +++
 rtl/parking_gate_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_ctrl_if.sv
// Request/status bundle between the parking gate controller and its requesters.
//   master : drives entry_req, exit_req, exit_spot; observes gates, pulses and status.
//   slave  : the controller side (parking_gate_ctrl).
interface parking_gate_ctrl_if;
   logic       entry_req;
   logic       exit_req;
   logic [1:0] exit_spot;
   logic       entry_gate_open;
   logic       exit_gate_open;
   logic       entry_ack;
   logic       entry_rej;
   logic       exit_ack;
   logic       exit_err;
   logic [1:0] assigned_spot;
   logic [3:0] spot_occ;
   logic [2:0] free_cnt;
   logic       full;
   logic [7:0] stat_entries;
   logic [7:0] stat_rejects;

   modport master (
      output entry_req, exit_req, exit_spot,
      input  entry_gate_open, exit_gate_open, entry_ack, entry_rej, exit_ack, exit_err,
      input  assigned_spot, spot_occ, free_cnt, full, stat_entries, stat_rejects
   );

   modport slave (
      input  entry_req, exit_req, exit_spot,
      output entry_gate_open, exit_gate_open, entry_ack, entry_rej, exit_ack, exit_err,
      output assigned_spot, spot_occ, free_cnt, full, stat_entries, stat_rejects
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate sequencer for a 4-spot parking lot. Owns the occupancy register, hands each
// arriving car the lowest free spot, arbitrates simultaneous requests and holds each gate open
// for GATE_OPEN_CYCLES cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : parking_gate_ctrl_if.slave (requests in; gates, pulses, occupancy, counts out)
// Optional feature macro PARK_STATS_EN: builds saturating entry/reject statistics counters;
// when undefined stat_entries/stat_rejects are tied to 0.
module parking_gate_ctrl #(
   parameter int unsigned NUM_SPOTS        = 4,
   parameter int unsigned GATE_OPEN_CYCLES = 8
) (
   input logic               clk,
   input logic               rst,
   parking_gate_ctrl_if.slave bus
);
   localparam int unsigned SpotW = $clog2(NUM_SPOTS);
   localparam int unsigned CntW  = $clog2(NUM_SPOTS + 1);

   typedef enum logic [1:0] {StIdle, StEntryOpen, StExitOpen} state_e;
   typedef enum logic {SideExit, SideEntry} side_e;

   state_e               state_q, state_d;
   side_e                last_q, last_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [NUM_SPOTS-1:0] occ_q, occ_d;
   logic [SpotW-1:0]     spot_q, spot_d;
   logic                 entry_arm_q, entry_arm_d;
   logic                 exit_arm_q, exit_arm_d;
   logic                 entry_ack_q, entry_ack_d;
   logic                 entry_rej_q, entry_rej_d;
   logic                 exit_ack_q, exit_ack_d;
   logic                 exit_err_q, exit_err_d;
   logic                 entry_open_q, entry_open_d;
   logic                 exit_open_q, exit_open_d;

   logic [SpotW-1:0] free_idx;
   logic [CntW-1:0]  free_cnt;
   logic             full;
   logic             entry_v, exit_v, entry_sel, exit_sel;

   // Lowest-index free spot and zero-bit count of the registered occupancy.
   always_comb begin
      free_idx = '0;
      free_cnt = '0;
      for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
         if (!occ_q[i]) free_idx = SpotW'(i);
      end
      for (int i = 0; i < NUM_SPOTS; i++) begin
         free_cnt = free_cnt + CntW'(!occ_q[i]);
      end
   end

   assign full = &occ_q;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      occ_d       = occ_q;
      spot_d      = spot_q;
      entry_ack_d = 1'b0;
      entry_rej_d = 1'b0;
      exit_ack_d  = 1'b0;
      exit_err_d  = 1'b0;
      // A request re-arms once it has been seen low.
      entry_arm_d = entry_arm_q | ~bus.entry_req;
      exit_arm_d  = exit_arm_q | ~bus.exit_req;
      entry_v     = bus.entry_req & entry_arm_q;
      exit_v      = bus.exit_req & exit_arm_q;
      entry_sel   = 1'b0;
      exit_sel    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Full lot favours exit; otherwise the side not served last wins. Loser stays armed.
            if (entry_v && exit_v) begin
               if (full || last_q == SideEntry) exit_sel = 1'b1;
               else                             entry_sel = 1'b1;
            end else begin
               entry_sel = entry_v;
               exit_sel  = exit_v;
            end

            if (entry_sel) begin
               entry_arm_d = 1'b0;
               if (full) begin
                  entry_rej_d = 1'b1;
               end else begin
                  occ_d[free_idx] = 1'b1;
                  spot_d          = free_idx;
                  last_d          = SideEntry;
                  cnt_d           = 8'(GATE_OPEN_CYCLES - 1);
                  entry_ack_d     = 1'b1;
                  state_d         = StEntryOpen;
               end
            end

            if (exit_sel) begin
               exit_arm_d = 1'b0;
               if (occ_q[bus.exit_spot]) begin
                  occ_d[bus.exit_spot] = 1'b0;
                  last_d               = SideExit;
                  cnt_d                = 8'(GATE_OPEN_CYCLES - 1);
                  exit_ack_d           = 1'b1;
                  state_d              = StExitOpen;
               end else begin
                  exit_err_d = 1'b1;
               end
            end
         end
         StEntryOpen, StExitOpen: begin
            if (cnt_q == 8'd0) state_d = StIdle;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = StIdle;
      endcase

      entry_open_d = (state_d == StEntryOpen);
      exit_open_d  = (state_d == StExitOpen);
   end

`ifdef PARK_STATS_EN
   logic [7:0] stat_entries_q, stat_entries_d;
   logic [7:0] stat_rejects_q, stat_rejects_d;

   always_comb begin
      stat_entries_d = stat_entries_q;
      stat_rejects_d = stat_rejects_q;
      if (entry_ack_q && stat_entries_q != 8'hff) stat_entries_d = stat_entries_q + 8'd1;
      if (entry_rej_q && stat_rejects_q != 8'hff) stat_rejects_d = stat_rejects_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_entries_q <= 8'd0;
         stat_rejects_q <= 8'd0;
      end else begin
         stat_entries_q <= stat_entries_d;
         stat_rejects_q <= stat_rejects_d;
      end
   end

   assign bus.stat_entries = stat_entries_q;
   assign bus.stat_rejects = stat_rejects_q;
`else
   assign bus.stat_entries = 8'd0;
   assign bus.stat_rejects = 8'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         last_q       <= SideExit;
         cnt_q        <= 8'd0;
         occ_q        <= '0;
         spot_q       <= '0;
         entry_arm_q  <= 1'b1;
         exit_arm_q   <= 1'b1;
         entry_ack_q  <= 1'b0;
         entry_rej_q  <= 1'b0;
         exit_ack_q   <= 1'b0;
         exit_err_q   <= 1'b0;
         entry_open_q <= 1'b0;
         exit_open_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         occ_q        <= occ_d;
         spot_q       <= spot_d;
         entry_arm_q  <= entry_arm_d;
         exit_arm_q   <= exit_arm_d;
         entry_ack_q  <= entry_ack_d;
         entry_rej_q  <= entry_rej_d;
         exit_ack_q   <= exit_ack_d;
         exit_err_q   <= exit_err_d;
         entry_open_q <= entry_open_d;
         exit_open_q  <= exit_open_d;
      end
   end

   assign bus.entry_gate_open = entry_open_q;
   assign bus.exit_gate_open  = exit_open_q;
   assign bus.entry_ack       = entry_ack_q;
   assign bus.entry_rej       = entry_rej_q;
   assign bus.exit_ack        = exit_ack_q;
   assign bus.exit_err        = exit_err_q;
   assign bus.assigned_spot   = spot_q;
   assign bus.spot_occ        = occ_q;
   assign bus.free_cnt        = free_cnt;
   assign bus.full            = full;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   parking_gate_ctrl_if bus();

   parking_gate_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef PARK_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int both_open  = 0;
   int multi_puls = 0;

   always @(negedge clk) begin
      if (bus.entry_gate_open && bus.exit_gate_open) both_open++;
      if (int'(bus.entry_ack) + int'(bus.entry_rej) + int'(bus.exit_ack) + int'(bus.exit_err) > 1)
         multi_puls++;
   end

   // Stimulus only: hold entry_req for a window, count events, then drop it for one cycle.
   task automatic do_entry(input int cycles, output int acks, output int rejs, output int opens);
      acks = 0; rejs = 0; opens = 0;
      bus.entry_req = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         acks  += int'(bus.entry_ack);
         rejs  += int'(bus.entry_rej);
         opens += int'(bus.entry_gate_open | bus.exit_gate_open);
      end
      bus.entry_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_exit(input logic [1:0] spot, input int cycles, output int acks,
                          output int errs, output int opens);
      acks = 0; errs = 0; opens = 0;
      bus.exit_spot = spot;
      bus.exit_req  = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         acks  += int'(bus.exit_ack);
         errs  += int'(bus.exit_err);
         opens += int'(bus.entry_gate_open | bus.exit_gate_open);
      end
      bus.exit_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.entry_req = 1'b0; bus.exit_req = 1'b0; bus.exit_spot = 2'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.spot_occ !== 4'b0000) begin failures++;
         $display("FAIL reset_occ got %b expected 0000", bus.spot_occ); end
      checks++; if (bus.free_cnt !== 3'd4) begin failures++;
         $display("FAIL reset_free_cnt got %0d expected 4", bus.free_cnt); end
      checks++; if ({bus.full, bus.entry_gate_open, bus.exit_gate_open} !== 3'b000) begin
         failures++; $display("FAIL reset_full_gates got %b expected 000",
                              {bus.full, bus.entry_gate_open, bus.exit_gate_open}); end
      checks++; if ({bus.entry_ack, bus.entry_rej, bus.exit_ack, bus.exit_err} !== 4'b0000) begin
         failures++; $display("FAIL reset_pulses got %b expected 0000",
                              {bus.entry_ack, bus.entry_rej, bus.exit_ack, bus.exit_err}); end
      checks++; if ({bus.assigned_spot, bus.stat_entries, bus.stat_rejects} !== 18'd0) begin
         failures++; $display("FAIL reset_spot_stats got %0d/%0d/%0d expected 0/0/0",
                              bus.assigned_spot, bus.stat_entries, bus.stat_rejects); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_entry_fill();
      int a, r, o;
      for (int g = 0; g < 3; g++) begin
         do_entry(12, a, r, o);
         checks++; if (a !== 1 || r !== 0) begin failures++;
            $display("FAIL fill_ack[%0d] got ack=%0d rej=%0d expected 1/0", g, a, r); end
         checks++; if (o !== 8) begin failures++;
            $display("FAIL fill_open_cycles[%0d] got %0d expected 8", g, o); end
         checks++; if (bus.assigned_spot !== 2'(g)) begin failures++;
            $display("FAIL fill_spot[%0d] got %0d expected %0d", g, bus.assigned_spot, g); end
      end
      checks++; if (bus.spot_occ !== 4'b0111 || bus.free_cnt !== 3'd1 || bus.full !== 1'b0) begin
         failures++; $display("FAIL fill_state got occ=%b free=%0d full=%b expected 0111/1/0",
                              bus.spot_occ, bus.free_cnt, bus.full); end
   endtask

   task automatic test_full_reject();
      int a, r, o;
      do_entry(12, a, r, o);
      checks++; if (a !== 1 || bus.assigned_spot !== 2'd3 || bus.full !== 1'b1) begin failures++;
         $display("FAIL fill_last got ack=%0d spot=%0d full=%b expected 1/3/1",
                  a, bus.assigned_spot, bus.full); end
      do_entry(20, a, r, o);
      checks++; if (r !== 1 || a !== 0) begin failures++;
         $display("FAIL full_rej got rej=%0d ack=%0d expected 1/0", r, a); end
      checks++; if (o !== 0) begin failures++;
         $display("FAIL full_no_gate got %0d open cycles expected 0", o); end
      checks++; if (bus.spot_occ !== 4'b1111 || bus.free_cnt !== 3'd0) begin failures++;
         $display("FAIL full_state got occ=%b free=%0d expected 1111/0",
                  bus.spot_occ, bus.free_cnt); end
      checks++; if (bus.stat_rejects !== (Stats ? 8'd1 : 8'd0)) begin failures++;
         $display("FAIL stat_rejects got %0d expected %0d", bus.stat_rejects, Stats ? 1 : 0); end
      checks++; if (bus.stat_entries !== (Stats ? 8'd4 : 8'd0)) begin failures++;
         $display("FAIL stat_entries got %0d expected %0d", bus.stat_entries, Stats ? 4 : 0); end
   endtask

   task automatic test_exit_err();
      int a, e, o;
      do_exit(2'd2, 12, a, e, o);
      checks++; if (a !== 1 || o !== 8 || bus.spot_occ !== 4'b1011) begin failures++;
         $display("FAIL exit2 got ack=%0d open=%0d occ=%b expected 1/8/1011", a, o, bus.spot_occ);
      end
      do_exit(2'd2, 6, a, e, o);
      checks++; if (e !== 1 || a !== 0 || o !== 0) begin failures++;
         $display("FAIL exit_err got err=%0d ack=%0d open=%0d expected 1/0/0", e, a, o); end
      checks++; if (bus.spot_occ !== 4'b1011) begin failures++;
         $display("FAIL exit_err_occ got %b expected 1011", bus.spot_occ); end
   endtask

   task automatic test_exit_ack();
      int a, e, o;
      do_exit(2'd1, 12, a, e, o);
      checks++; if (a !== 1 || e !== 0 || o !== 8) begin failures++;
         $display("FAIL exit_ack got ack=%0d err=%0d open=%0d expected 1/0/8", a, e, o); end
      checks++; if (bus.spot_occ !== 4'b1001 || bus.free_cnt !== 3'd2) begin failures++;
         $display("FAIL exit_ack_occ got %b/%0d expected 1001/2", bus.spot_occ, bus.free_cnt); end
   endtask

   task automatic test_priority_full();
      int a, r, o, exit_k, entry_k, n_en, n_ex;
      logic [3:0] occ_at1;
      do_entry(12, a, r, o);
      do_entry(12, a, r, o);
      checks++; if (bus.spot_occ !== 4'b1111) begin failures++;
         $display("FAIL prio_setup got %b expected 1111", bus.spot_occ); end
      exit_k = 0; entry_k = 0; n_en = 0; n_ex = 0; occ_at1 = 4'hx;
      bus.exit_spot = 2'd3; bus.exit_req = 1'b1; bus.entry_req = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) occ_at1 = bus.spot_occ;
         if (bus.exit_ack)  begin n_ex++; exit_k = k; end
         if (bus.entry_ack) begin n_en++; entry_k = k; end
      end
      bus.exit_req = 1'b0; bus.entry_req = 1'b0;
      @(negedge clk);
      checks++; if (exit_k !== 1 || n_ex !== 1 || occ_at1 !== 4'b0111) begin failures++;
         $display("FAIL prio_exit got cycle=%0d n=%0d occ=%b expected 1/1/0111",
                  exit_k, n_ex, occ_at1); end
      checks++; if (entry_k !== 10 || n_en !== 1) begin failures++;
         $display("FAIL prio_entry got cycle=%0d n=%0d expected 10/1", entry_k, n_en); end
      checks++; if (bus.assigned_spot !== 2'd3 || bus.spot_occ !== 4'b1111) begin failures++;
         $display("FAIL prio_spot got %0d/%b expected 3/1111", bus.assigned_spot, bus.spot_occ);
      end
   endtask

   task automatic test_alternate();
      int a, e, o, n;
      int seq [4];
      bit drop_e, drop_x;
      do_exit(2'd0, 12, a, e, o);
      do_exit(2'd1, 12, a, e, o);
      do_entry(12, a, e, o);
      checks++; if (bus.spot_occ !== 4'b1101 || bus.assigned_spot !== 2'd0) begin failures++;
         $display("FAIL alt_setup got %b/%0d expected 1101/0", bus.spot_occ, bus.assigned_spot);
      end
      // Last grant was an entry, so with both armed the exit should go first, then alternate.
      n = 0; drop_e = 0; drop_x = 0;
      for (int i = 0; i < 4; i++) seq[i] = 0;
      bus.exit_spot = 2'd0; bus.exit_req = 1'b1; bus.entry_req = 1'b1;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (drop_e) begin bus.entry_req = 1'b1; drop_e = 0; end
         if (drop_x) begin bus.exit_req = 1'b1; drop_x = 0; end
         if (bus.entry_ack) begin
            if (n < 4) seq[n] = 1;
            n++; bus.entry_req = 1'b0; drop_e = 1;
         end
         if (bus.exit_ack) begin
            if (n < 4) seq[n] = 2;
            n++; bus.exit_req = 1'b0; drop_x = 1;
         end
      end
      bus.exit_req = 1'b0; bus.entry_req = 1'b0;
      @(negedge clk);
      checks++; if (n !== 4 || seq[0] !== 2 || seq[1] !== 1 || seq[2] !== 2 || seq[3] !== 1)
      begin failures++;
         $display("FAIL alt_order got n=%0d seq=%0d%0d%0d%0d expected 4 2121 (2=exit 1=entry)",
                  n, seq[0], seq[1], seq[2], seq[3]); end
      checks++; if (bus.spot_occ !== 4'b1101) begin failures++;
         $display("FAIL alt_occ got %b expected 1101", bus.spot_occ); end
   endtask

   task automatic test_reset_mid();
      int a, r, o;
      bus.entry_req = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (bus.entry_gate_open !== 1'b1 || bus.assigned_spot !== 2'd1) begin failures++;
         $display("FAIL mid_pre got gate=%b spot=%0d expected 1/1",
                  bus.entry_gate_open, bus.assigned_spot); end
      rst = 1'b1;
      #1;
      checks++; if (bus.entry_gate_open !== 1'b0 || bus.spot_occ !== 4'b0000) begin failures++;
         $display("FAIL mid_rst got gate=%b occ=%b expected 0/0000",
                  bus.entry_gate_open, bus.spot_occ); end
      checks++; if (bus.free_cnt !== 3'd4 || bus.full !== 1'b0) begin failures++;
         $display("FAIL mid_rst_cnt got %0d/%b expected 4/0", bus.free_cnt, bus.full); end
      bus.entry_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_entry(12, a, r, o);
      checks++; if (a !== 1 || bus.assigned_spot !== 2'd0 || bus.spot_occ !== 4'b0001) begin
         failures++; $display("FAIL mid_after got ack=%0d spot=%0d occ=%b expected 1/0/0001",
                              a, bus.assigned_spot, bus.spot_occ); end
   endtask

   task automatic test_stats();
      int a, e, o;
      do_exit(2'd0, 12, a, e, o);
      for (int i = 0; i < 300; i++) begin
         do_entry(12, a, e, o);
         do_exit(2'd0, 12, a, e, o);
      end
      checks++; if (bus.stat_entries !== (Stats ? 8'd255 : 8'd0)) begin failures++;
         $display("FAIL stat_sat got %0d expected %0d", bus.stat_entries, Stats ? 255 : 0); end
      checks++; if (bus.stat_rejects !== 8'd0 || bus.spot_occ !== 4'b0000) begin failures++;
         $display("FAIL stat_rej_occ got %0d/%b expected 0/0000",
                  bus.stat_rejects, bus.spot_occ); end
   endtask

   task automatic test_exclusion();
      checks++; if (both_open !== 0) begin failures++;
         $display("FAIL gates_exclusive got %0d overlap cycles expected 0", both_open); end
      checks++; if (multi_puls !== 0) begin failures++;
         $display("FAIL single_pulse got %0d multi-pulse cycles expected 0", multi_puls); end
   endtask

   initial begin
      test_reset();
      test_entry_fill();
      test_full_reject();
      test_exit_err();
      test_exit_ack();
      test_priority_full();
      test_alternate();
      test_reset_mid();
      test_stats();
      test_exclusion();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
